secuenciador_coef_iir: RTL and testbench
========================================

Name: secuenciador_coef_iir

Overview:
- Parametrised, multi-mode successor to the fixed 20 Hz high-pass coefficient table.
- Holds biquad coefficient sets for several filter modes.
- On each new-sample start pulse, streams that mode's six coefficients, in order, to the downstream MAC over a valid/ready handshake.
- Sits between the sample-rate strobe logic and the shared multiply-accumulate datapath. It also tags each coefficient with its index and with the audio channel it belongs to.

Parameters:
- CANT_BITS, 25, coefficient width (signed two's complement, Q10.14; 1.0 = 0x4000 for the 25-bit default).
- N_CANALES, 2, number of audio channels sharing the MAC; channel tag width is clog2(N_CANALES), minimum 1.
- N_MODOS, 4, number of coefficient sets; mode select width is clog2(N_MODOS).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin a coefficient sequence
- modo  input  clog2(N_MODOS)  filter mode, sampled on an accepted start
- canal  input  clog2(N_CANALES)  channel tag, sampled on an accepted start
- cte_ready  input  1  MAC accepts the current coefficient
- cte  output  CANT_BITS  current coefficient
- cte_idx  output  3  coefficient index (0..5)
- cte_canal  output  clog2(N_CANALES)  captured channel tag
- cte_valid  output  1  cte, cte_idx and cte_canal are valid
- done  output  1  one-cycle pulse after the last coefficient is accepted
- ovr  output  1  one-cycle pulse when a start arrives while busy
- modo_err  output  1  sticky; set when a start is accepted with modo >= number of defined modes

Behaviour:
- Reset: FSM in IDLE. cte, cte_idx, cte_canal, cte_valid, done, ovr and modo_err are all 0. Captured mode is 0.
- Coefficient order and index:
  - 0: gain
  - 1: -a1
  - 2: -a2
  - 3: b0
  - 4: b1
  - 5: b2
- Defined modes:
  - 0 = bypass: gain 0x4000, b0 0x4000, all others 0.
  - 1 = high-pass 20 Hz: gain 0x4000, -a1 0x7FBE, -a2 0x1FFC042, b0 0x3FDF, b1 0x1FF8042, b2 0x3FDF.
  - 2 = low-pass and 3 = band-pass: values fixed in the package.
- Mode handling:
  - An undefined mode plays the bypass set and sets modo_err.
  - modo_err clears only on reset.
- FSM has two states, IDLE and RUN.
- IDLE:
  - On start, capture modo and canal, set cte_idx = 0, go to RUN.
  - cte_valid rises in the next cycle (latency 1).
- RUN:
  - cte_valid = 1. cte is a registered lookup of (captured mode, cte_idx).
  - The handshake completes in any cycle with cte_valid & cte_ready. cte_idx then increments and the new cte is presented in the next cycle, which allows back-to-back transfers.
  - While cte_ready = 0, all outputs hold stable.
  - Handshake at idx 5: go to IDLE, cte_valid = 0, done = 1 for exactly one cycle.
- Throughput: with cte_ready tied high, start at cycle t gives valid during t+1..t+6 and done at t+7.
- Collisions and mid-sequence changes:
  - A start while in RUN is ignored (sequence not restarted, mode not re-captured) and ovr pulses for one cycle.
  - A start in the same cycle done is high is accepted normally.
  - Changes on modo or canal during RUN have no effect until the next accepted start.
- Reset mid-sequence: returns immediately to IDLE. No done pulse is produced.
- Width rule: package constants are defined at 25 bits and sign-extended or truncated (low bits dropped, arithmetic shift) to CANT_BITS so that 1.0 stays the top-of-range Q format.

Optional Feature:
- Macro: COEF_WR_EN.
- With COEF_WR_EN defined:
  - Coefficients are held in a register file, loaded from the package defaults on reset.
  - Extra inputs: wr_en (1), wr_modo (clog2(N_MODOS)), wr_idx (3), wr_dato (CANT_BITS). Extra output: wr_err (1).
  - A write is accepted only in IDLE and takes effect the next cycle.
  - A write during RUN, or one with wr_idx > 5, is dropped and wr_err pulses for one cycle.
- Without COEF_WR_EN: coefficients are a constant ROM, the extra ports do not exist, and tables are read-only.

Decomposition:
- Package pkg_coef_iir holds:
  - coefficient index localparams (IDX_GAIN..IDX_B2);
  - mode codes (MODO_BYPASS, MODO_HP20, MODO_LP, MODO_BP);
  - 25-bit default coefficient constants per mode;
  - a function returning the default coefficient for (mode, idx).
- One sub-module, tabla_coef_iir: the lookup (ROM, or register file under COEF_WR_EN), with registered read.
- The FSM, handshake and flags stay in the top.

Test Plan:
- Bypass, ready high: start with modo=0, canal=1 -> valid t+1..t+6, cte = 0x4000, 0, 0, 0x4000, 0, 0, cte_canal=1 throughout, done at t+7.
- HP20 with backpressure: modo=1, cte_ready low on alternate cycles -> cte sequence 0x4000, 0x7FBE, 0x1FFC042, 0x3FDF, 0x1FF8042, 0x3FDF; outputs hold stable while ready is low; done only after the idx-5 handshake.
- Overrun: second start at t+3 with modo=2 -> ovr pulses at t+4; sequence continues with mode 1 values; no restart.
- Undefined mode (N_MODOS=8): start with modo=5 -> bypass values emitted, modo_err=1 and stays set after later valid starts.
- Reset at idx 3 -> all outputs 0 asynchronously; no done pulse; a later start gives a full 6-coefficient sequence.
- COEF_WR_EN: write mode 1 idx 3 = 0x1234 in IDLE, then start -> b0 reads 0x1234. A write during RUN -> wr_err pulse; table unchanged.

Source files
------------

// File: rtl/secuenciador_coef_iir_pkg.sv
// -----------------------------------------------------------------------------
// pkg_coef_iir
// Shared definitions for the biquad coefficient sequencer:
//   - coefficient index codes (IDX_GAIN..IDX_B2) in streaming order
//   - filter mode codes (MODO_BYPASS, MODO_HP20, MODO_LP, MODO_BP)
//   - 25-bit Q10.14 default coefficient sets (1.0 = 25'h0004000)
//   - coefDefecto(): default coefficient for a (mode, index) pair
//   - anchoMin1(): clog2 with a floor of one bit, used for select widths
// No ports (package).
// -----------------------------------------------------------------------------
package pkg_coef_iir;

   localparam int N_COEF = 6;

   localparam logic [2:0] IDX_GAIN = 3'd0;
   localparam logic [2:0] IDX_NA1  = 3'd1;
   localparam logic [2:0] IDX_NA2  = 3'd2;
   localparam logic [2:0] IDX_B0   = 3'd3;
   localparam logic [2:0] IDX_B1   = 3'd4;
   localparam logic [2:0] IDX_B2   = 3'd5;

   localparam int MODO_BYPASS = 0;
   localparam int MODO_HP20   = 1;
   localparam int MODO_LP     = 2;
   localparam int MODO_BP     = 3;
   localparam int N_MODOS_DEF = 4;

   typedef logic [24:0] coef25_t;

   // Select widths never collapse to zero bits, even for a single channel/mode.
   function automatic int anchoMin1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Default tables. The feedback terms are stored already negated (-a1, -a2)
   // so the MAC only ever accumulates. Unknown modes fall back to bypass.
   function automatic coef25_t coefDefecto(input int modo, input logic [2:0] idx);
      coef25_t r;
      r = '0;
      case (modo)
         MODO_HP20: begin
            case (idx)
               IDX_GAIN: r = 25'h0004000;
               IDX_NA1:  r = 25'h0007FBE;
               IDX_NA2:  r = 25'h1FFC042;
               IDX_B0:   r = 25'h0003FDF;
               IDX_B1:   r = 25'h1FF8042;
               IDX_B2:   r = 25'h0003FDF;
               default:  r = '0;
            endcase
         end
         MODO_LP: begin
            case (idx)
               IDX_GAIN: r = 25'h0004000;
               IDX_NA1:  r = 25'h0007429;
               IDX_NA2:  r = 25'h1FFCAD1;
               IDX_B0:   r = 25'h0000040;
               IDX_B1:   r = 25'h0000080;
               IDX_B2:   r = 25'h0000040;
               default:  r = '0;
            endcase
         end
         MODO_BP: begin
            case (idx)
               IDX_GAIN: r = 25'h0004000;
               IDX_NA1:  r = 25'h0007333;
               IDX_NA2:  r = 25'h1FFC99A;
               IDX_B0:   r = 25'h00004CD;
               IDX_B1:   r = 25'h0000000;
               IDX_B2:   r = 25'h1FFFB33;
               default:  r = '0;
            endcase
         end
         default: begin
            r = (idx == IDX_GAIN || idx == IDX_B0) ? 25'h0004000 : 25'h0000000;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/secuenciador_coef_iir_if.sv
// -----------------------------------------------------------------------------
// secuenciador_coef_iir_if
// Bundles the start/mode inputs and the coefficient stream toward the MAC.
//   master : the sequencer side (receives start/modo/canal/cte_ready, drives
//            cte, cte_idx, cte_canal, cte_valid, done, ovr, modo_err)
//   slave  : the environment side (strobe logic + MAC), mirror directions
// Optional macro COEF_WR_EN adds wr_en/wr_modo/wr_idx/wr_dato and wr_err.
// -----------------------------------------------------------------------------
interface secuenciador_coef_iir_if #(
   parameter int CANT_BITS = 25,
   parameter int N_CANALES = 2,
   parameter int N_MODOS   = 4
);
   localparam int MW = pkg_coef_iir::anchoMin1(N_MODOS);
   localparam int CW = pkg_coef_iir::anchoMin1(N_CANALES);

   logic                 start;
   logic [MW-1:0]        modo;
   logic [CW-1:0]        canal;
   logic                 cte_ready;
   logic [CANT_BITS-1:0] cte;
   logic [2:0]           cte_idx;
   logic [CW-1:0]        cte_canal;
   logic                 cte_valid;
   logic                 done;
   logic                 ovr;
   logic                 modo_err;

`ifdef COEF_WR_EN
   logic                 wr_en;
   logic [MW-1:0]        wr_modo;
   logic [2:0]           wr_idx;
   logic [CANT_BITS-1:0] wr_dato;
   logic                 wr_err;

   modport master (input  start, modo, canal, cte_ready, wr_en, wr_modo, wr_idx, wr_dato,
                   output cte, cte_idx, cte_canal, cte_valid, done, ovr, modo_err, wr_err);
   modport slave  (output start, modo, canal, cte_ready, wr_en, wr_modo, wr_idx, wr_dato,
                   input  cte, cte_idx, cte_canal, cte_valid, done, ovr, modo_err, wr_err);
`else
   modport master (input  start, modo, canal, cte_ready,
                   output cte, cte_idx, cte_canal, cte_valid, done, ovr, modo_err);
   modport slave  (output start, modo, canal, cte_ready,
                   input  cte, cte_idx, cte_canal, cte_valid, done, ovr, modo_err);
`endif
endinterface

// File: rtl/secuenciador_coef_iir_tabla.sv
// -----------------------------------------------------------------------------
// tabla_coef_iir
// Coefficient store with a registered read port.
//   clk, reset    : clock, asynchronous active-high reset
//   rd_en_i       : load the read register; when low it loads zero
//   rd_modo_i     : mode to read
//   rd_idx_i      : coefficient index to read (0..5)
//   rd_dato_o     : registered coefficient, CANT_BITS wide
// With macro COEF_WR_EN the store is a register file reloaded from the package
// defaults on reset, written through wr_en_i/wr_modo_i/wr_idx_i/wr_dato_i
// (the caller only asserts wr_en_i for legal writes). Otherwise it is a ROM.
// -----------------------------------------------------------------------------
module tabla_coef_iir
   import pkg_coef_iir::*;
#(
   parameter int CANT_BITS = 25,
   parameter int N_MODOS   = 4,
   localparam int MW       = pkg_coef_iir::anchoMin1(N_MODOS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rd_en_i,
   input  logic [MW-1:0]        rd_modo_i,
   input  logic [2:0]           rd_idx_i,
`ifdef COEF_WR_EN
   input  logic                 wr_en_i,
   input  logic [MW-1:0]        wr_modo_i,
   input  logic [2:0]           wr_idx_i,
   input  logic [CANT_BITS-1:0] wr_dato_i,
`endif
   output logic [CANT_BITS-1:0] rd_dato_o
);
   localparam int ANCHO_EXT = (CANT_BITS > 25) ? CANT_BITS : 25;

   logic [CANT_BITS-1:0] lectura;
   logic [CANT_BITS-1:0] rdDato_q;

   // Fit a 25-bit Q10.14 constant to CANT_BITS keeping 1.0 at the same place
   // relative to the top: sign-extend when wider, arithmetic shift when narrower.
   function automatic logic [CANT_BITS-1:0] ajustar(input coef25_t v);
      logic signed [ANCHO_EXT-1:0] ext;
      ext = ANCHO_EXT'($signed(v));
      return CANT_BITS'(ext >>> (ANCHO_EXT - CANT_BITS));
   endfunction

`ifdef COEF_WR_EN
   logic [CANT_BITS-1:0] banco_q [N_MODOS][N_COEF];

   // Register file: defaults come back on every reset, writes land one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int m = 0; m < N_MODOS; m++) begin
            for (int i = 0; i < N_COEF; i++) begin
               banco_q[m][i] <= ajustar(coefDefecto(m, 3'(i)));
            end
         end
      end else if (wr_en_i) begin
         banco_q[wr_modo_i][wr_idx_i] <= wr_dato_i;
      end
   end

   // Asynchronous array read feeding the output register.
   always_comb begin
      lectura = banco_q[rd_modo_i][rd_idx_i];
   end
`else
   // Constant ROM built from the package defaults.
   always_comb begin
      lectura = ajustar(coefDefecto(int'(rd_modo_i), rd_idx_i));
   end
`endif

   // Read register: zero whenever the sequencer is not presenting a coefficient.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdDato_q <= '0;
      end else begin
         rdDato_q <= rd_en_i ? lectura : '0;
      end
   end

   assign rd_dato_o = rdDato_q;

endmodule

// File: rtl/secuenciador_coef_iir.sv
// -----------------------------------------------------------------------------
// secuenciador_coef_iir
// On each accepted start pulse, streams the six biquad coefficients of the
// selected mode (gain, -a1, -a2, b0, b1, b2) to the MAC over valid/ready,
// tagged with index and channel.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : secuenciador_coef_iir_if.master (start/modo/canal/cte_ready in;
//                cte/cte_idx/cte_canal/cte_valid/done/ovr/modo_err out)
// Optional macro COEF_WR_EN: writable coefficient tables (wr_* / wr_err).
// -----------------------------------------------------------------------------
module secuenciador_coef_iir
   import pkg_coef_iir::*;
#(
   parameter int CANT_BITS = 25,
   parameter int N_CANALES = 2,
   parameter int N_MODOS   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   secuenciador_coef_iir_if.master  bus
);
   localparam int MW    = anchoMin1(N_MODOS);
   localparam int CW    = anchoMin1(N_CANALES);
   localparam int N_DEF = (N_MODOS < N_MODOS_DEF) ? N_MODOS : N_MODOS_DEF;

   typedef enum logic {IDLE, RUN} estado_t;

   estado_t              estado_q, estado_d;
   logic [MW-1:0]        modo_q, modo_d;
   logic [CW-1:0]        canal_q, canal_d;
   logic [2:0]           idx_q, idx_d;
   logic                 done_q, done_d;
   logic                 ovr_q, ovr_d;
   logic                 modoErr_q, modoErr_d;
   logic                 modoInvalido;
   logic [CANT_BITS-1:0] cteTabla;

   // Next-state logic. In RUN, cte_valid is the state itself, so a handshake
   // is simply RUN & cte_ready. Undefined modes are captured as bypass so the
   // table never sees them.
   always_comb begin
      estado_d     = estado_q;
      modo_d       = modo_q;
      canal_d      = canal_q;
      idx_d        = idx_q;
      done_d       = 1'b0;
      ovr_d        = 1'b0;
      modoErr_d    = modoErr_q;
      modoInvalido = int'(bus.modo) >= N_DEF;
      case (estado_q)
         IDLE: begin
            if (bus.start) begin
               estado_d = RUN;
               idx_d    = IDX_GAIN;
               canal_d  = bus.canal;
               modo_d   = modoInvalido ? MW'(MODO_BYPASS) : bus.modo;
               if (modoInvalido) begin
                  modoErr_d = 1'b1;
               end
            end
         end
         RUN: begin
            ovr_d = bus.start;
            if (bus.cte_ready) begin
               if (idx_q == IDX_B2) begin
                  estado_d = IDLE;
                  idx_d    = IDX_GAIN;
                  done_d   = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: estado_d = IDLE;
      endcase
   end

   // State and flag registers; reset drops any sequence in flight without done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q  <= IDLE;
         modo_q    <= '0;
         canal_q   <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         modoErr_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         modo_q    <= modo_d;
         canal_q   <= canal_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
         modoErr_q <= modoErr_d;
      end
   end

`ifdef COEF_WR_EN
   logic wrOk;
   logic wrErr_q, wrErr_d;

   // Writes are only legal between sequences so a stream never mixes old/new sets.
   always_comb begin
      wrOk    = bus.wr_en && (estado_q == IDLE) && (bus.wr_idx <= IDX_B2);
      wrErr_d = bus.wr_en && !wrOk;
   end

   // One-cycle pulse for a dropped write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrErr_q <= 1'b0;
      end else begin
         wrErr_q <= wrErr_d;
      end
   end

   assign bus.wr_err = wrErr_q;
`endif

   // The table is addressed with next-state values so its registered output
   // lines up with cte_idx in the same cycle, allowing back-to-back transfers.
   tabla_coef_iir #(
      .CANT_BITS (CANT_BITS),
      .N_MODOS   (N_MODOS)
   ) u_tabla (
      .clk       (clk),
      .reset     (reset),
      .rd_en_i   (estado_d == RUN),
      .rd_modo_i (modo_d),
      .rd_idx_i  (idx_d),
`ifdef COEF_WR_EN
      .wr_en_i   (wrOk),
      .wr_modo_i (bus.wr_modo),
      .wr_idx_i  (bus.wr_idx),
      .wr_dato_i (bus.wr_dato),
`endif
      .rd_dato_o (cteTabla)
   );

   assign bus.cte       = cteTabla;
   assign bus.cte_idx   = idx_q;
   assign bus.cte_canal = canal_q;
   assign bus.cte_valid = (estado_q == RUN);
   assign bus.done      = done_q;
   assign bus.ovr       = ovr_q;
   assign bus.modo_err  = modoErr_q;

endmodule

// File: tb/tb_secuenciador_coef_iir.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_coef_iir
// Directed bench for secuenciador_coef_iir built with N_MODOS = 8 so that
// undefined modes (4..7) can be exercised. Expected coefficients are the
// hand-written tables below. The COEF_WR_EN section runs only when the macro
// is defined.
// -----------------------------------------------------------------------------
module tb_secuenciador_coef_iir;

   localparam int CB = 25;
   localparam int NC = 2;
   localparam int NM = 8;

   logic        clk = 1'b0;
   logic        reset;
   int          nChecks = 0;
   int          nPass   = 0;
   logic [24:0] hpB0    = 25'h0003FDF;

   secuenciador_coef_iir_if #(.CANT_BITS(CB), .N_CANALES(NC), .N_MODOS(NM)) bus ();

   secuenciador_coef_iir #(.CANT_BITS(CB), .N_CANALES(NC), .N_MODOS(NM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Step to just after the next rising edge, where outputs are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Hand-computed coefficient sequences: mode 1 is HP20, everything else the
   // bench uses plays bypass (mode 0 and undefined modes).
   function automatic logic [24:0] expCoef(input int m, input int k);
      if (m == 1) begin
         case (k)
            0:       return 25'h0004000;
            1:       return 25'h0007FBE;
            2:       return 25'h1FFC042;
            3:       return hpB0;
            4:       return 25'h1FF8042;
            default: return 25'h0003FDF;
         endcase
      end
      return (k == 0 || k == 3) ? 25'h0004000 : 25'h0000000;
   endfunction

   // One-cycle start pulse with the given mode and channel.
   task automatic applyStimulus(input int m, input int c);
      bus.start = 1'b1;
      bus.modo  = 3'(m);
      bus.canal = 1'(c);
      tick();
      bus.start = 1'b0;
   endtask

   // Follows one sequence from its first valid cycle to the done cycle.
   // alternate: cte_ready low on even cycles. ovrAt: loop cycle in which a
   // colliding start (with changed modo/canal) is driven.
   task automatic playSeq(input string tag, input int m, input int c,
                          input bit alternate, input int ovrAt);
      int   k = 0;
      int   n = 0;
      logic rdy;
      while (k < 6 && n < 40) begin
         rdy = alternate ? n[0] : 1'b1;
         bus.cte_ready = rdy;
         if (n == ovrAt) begin
            bus.start = 1'b1;
            bus.modo  = 3'd2;
            bus.canal = 1'(~c);
         end else begin
            bus.start = 1'b0;
         end
         checkOutput({tag, "_valid"}, 32'(bus.cte_valid), 32'(1));
         checkOutput({tag, "_cte"},   32'(bus.cte),       32'(expCoef(m, k)));
         checkOutput({tag, "_idx"},   32'(bus.cte_idx),   32'(k));
         checkOutput({tag, "_canal"}, 32'(bus.cte_canal), 32'(c));
         checkOutput({tag, "_done"},  32'(bus.done),      32'(0));
         checkOutput({tag, "_ovr"},   32'(bus.ovr),       32'(n == ovrAt + 1));
         if (rdy) k++;
         n++;
         tick();
      end
      bus.start     = 1'b0;
      bus.cte_ready = 1'b1;
      checkOutput({tag, "_len"},      32'(k),             32'(6));
      checkOutput({tag, "_donePulse"}, 32'(bus.done),     32'(1));
      checkOutput({tag, "_validOff"}, 32'(bus.cte_valid), 32'(0));
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.modo      = '0;
      bus.canal     = '0;
      bus.cte_ready = 1'b1;
`ifdef COEF_WR_EN
      bus.wr_en     = 1'b0;
      bus.wr_modo   = '0;
      bus.wr_idx    = '0;
      bus.wr_dato   = '0;
`endif
      tick();
      tick();
      checkOutput("rst_cte",   32'(bus.cte),       32'(0));
      checkOutput("rst_idx",   32'(bus.cte_idx),   32'(0));
      checkOutput("rst_canal", 32'(bus.cte_canal), 32'(0));
      checkOutput("rst_valid", 32'(bus.cte_valid), 32'(0));
      checkOutput("rst_done",  32'(bus.done),      32'(0));
      checkOutput("rst_ovr",   32'(bus.ovr),       32'(0));
      checkOutput("rst_err",   32'(bus.modo_err),  32'(0));
      reset = 1'b0;
      tick();

      // Bypass with ready tied high: valid t+1..t+6, done t+7.
      applyStimulus(0, 1);
      playSeq("byp", 0, 1, 1'b0, 1000);
      tick();
      checkOutput("byp_doneOnce", 32'(bus.done), 32'(0));

      // HP20 with backpressure on alternate cycles.
      applyStimulus(1, 0);
      playSeq("hp", 1, 0, 1'b1, 1000);
      tick();
      checkOutput("hp_doneOnce", 32'(bus.done), 32'(0));

      // Overrun: second start at t+3 is ignored, ovr at t+4.
      applyStimulus(1, 1);
      playSeq("ovr", 1, 1, 1'b0, 2);
      checkOutput("err_before", 32'(bus.modo_err), 32'(0));

      // Start in the done cycle, with an undefined mode: bypass + sticky error.
      applyStimulus(5, 0);
      playSeq("undef", 5, 0, 1'b0, 1000);
      checkOutput("err_set", 32'(bus.modo_err), 32'(1));
      tick();
      applyStimulus(0, 1);
      playSeq("after", 0, 1, 1'b0, 1000);
      checkOutput("err_sticky", 32'(bus.modo_err), 32'(1));
      tick();

      // Reset while idx 3 is presented.
      applyStimulus(1, 1);
      tick();
      tick();
      tick();
      checkOutput("mid_idx", 32'(bus.cte_idx), 32'(3));
      reset = 1'b1;
      #1;
      checkOutput("arst_cte",   32'(bus.cte),       32'(0));
      checkOutput("arst_idx",   32'(bus.cte_idx),   32'(0));
      checkOutput("arst_canal", 32'(bus.cte_canal), 32'(0));
      checkOutput("arst_valid", 32'(bus.cte_valid), 32'(0));
      checkOutput("arst_err",   32'(bus.modo_err),  32'(0));
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput("arst_noDone",  32'(bus.done),      32'(0));
         checkOutput("arst_idleOff", 32'(bus.cte_valid), 32'(0));
      end
      applyStimulus(1, 1);
      playSeq("rst", 1, 1, 1'b0, 1000);
      tick();

`ifdef COEF_WR_EN
      // Legal write in IDLE, then read it back through a sequence.
      bus.wr_en   = 1'b1;
      bus.wr_modo = 3'd1;
      bus.wr_idx  = 3'd3;
      bus.wr_dato = 25'h0001234;
      tick();
      bus.wr_en = 1'b0;
      checkOutput("wr_okNoErr", 32'(bus.wr_err), 32'(0));
      hpB0 = 25'h0001234;
      applyStimulus(1, 0);
      playSeq("wr", 1, 0, 1'b0, 1000);
      tick();

      // Out-of-range index is dropped.
      bus.wr_en  = 1'b1;
      bus.wr_idx = 3'd6;
      tick();
      bus.wr_en = 1'b0;
      checkOutput("wr_idxErr", 32'(bus.wr_err), 32'(1));
      tick();
      checkOutput("wr_errPulse", 32'(bus.wr_err), 32'(0));

      // Write during RUN is dropped and the table keeps its value.
      applyStimulus(0, 0);
      bus.wr_en   = 1'b1;
      bus.wr_modo = 3'd1;
      bus.wr_idx  = 3'd0;
      bus.wr_dato = 25'h0005555;
      tick();
      bus.wr_en = 1'b0;
      checkOutput("wr_runErr", 32'(bus.wr_err), 32'(1));
      for (int i = 0; i < 20 && !bus.done; i++) begin
         tick();
      end
      checkOutput("wr_runDone", 32'(bus.done), 32'(1));
      tick();
      applyStimulus(1, 0);
      playSeq("wrKeep", 1, 0, 1'b0, 1000);
      tick();
`endif

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
